// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: command opcodes,
// FSM states and the default operand width.
package hilo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_DIVU  = 2'd1;
  localparam logic [1:0] OP_MTHI  = 2'd2;
  localparam logic [1:0] OP_MTLO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } hilo_state_e;

endpackage

// File: rtl/hilo_div_step.sv
// One combinational restoring-division step: shift {rem,quot} left by one,
// subtract the divisor and keep the difference only if it did not borrow.
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  always_comb begin
    shifted = {rem[WIDTH-1:0], quot[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    // rem[WIDTH] set means the shifted value overflowed WIDTH+1 bits, so it
    // certainly exceeds the divisor even though the subtraction wrapped.
    fits    = rem[WIDTH] | ~trial[WIDTH+1];
    if (fits) begin
      rem_next  = trial[WIDTH:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = shifted;
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an inline shift-add multiplier and a restoring
// divider; MULTU/DIVU take WIDTH+1 busy cycles, MTHI/MTLO complete at once.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output hilo_state_e      dbg_state
);

  // Handshake: a command is accepted on a rising edge where start=1 and
  // busy=0; with busy=1 start is ignored and the issuer must hold off.
  hilo_state_e        state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d, divisor_q, divisor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quot;

  hilo_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_zero_d = 1'b0;
          case (op)
            OP_MTHI: begin
              hi_d   = src_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = src_a;
              done_d = 1'b1;
            end
            OP_MULTU: begin
              mcand_d  = {{WIDTH{1'b0}}, src_a};
              mplier_d = src_b;
              acc_d    = '0;
              cnt_d    = '0;
              is_div_d = 1'b0;
              busy_d   = 1'b1;
              state_d  = ST_MUL;
            end
            default: begin
              quot_d    = src_a;
              divisor_d = src_b;
              rem_d     = '0;
              cnt_d     = '0;
              is_div_d  = 1'b1;
              busy_d    = 1'b1;
              state_d   = ST_DIV;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FINISH;
      end
      ST_DIV: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FINISH;
      end
      default: begin
        if (is_div_q) begin
          lo_d       = quot_q;
          hi_d       = rem_q[WIDTH-1:0];
          div_zero_d = (divisor_q == '0);
        end else begin
          {hi_d, lo_d} = acc_q;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign dbg_state = state_q;

endmodule
